ps2_scancode_receiver: RTL and testbench
========================================

// Module: ps2_scancode_receiver
// PURPOSE
//   Receives PS/2 keyboard frames: 11-bit, device-clocked, LSB first, odd parity.
//   Outputs each valid scan-code byte and holds the most recent good code.
//   Sits directly upstream of the hex-to-seven-segment decoders.
//   last_code[7:4] and last_code[3:0] each drive one 4-bit decoder digit.
// PARAMETERS
//   FILTER_LEN      8      consecutive equal ps2_clk samples needed to accept a level change
//   TIMEOUT_CYCLES  50000  clk cycles without a ps2_clk fall mid-frame before abort (1 ms @ 50 MHz)
// PORTS
//   clk         in   1  system clock, single domain
//   rst_n       in   1  asynchronous, active-low reset
//   ps2_clk     in   1  raw PS/2 clock from the keyboard, asynchronous
//   ps2_data    in   1  raw PS/2 data from the keyboard, asynchronous
//   scan_code   out  8  received byte; valid while code_valid=1
//   code_valid  out  1  one-cycle pulse per good frame
//   last_code   out  8  last good scan code, held until the next good frame
//   parity_err  out  1  one-cycle pulse: stop bit good, parity bad
//   frame_err   out  1  one-cycle pulse: stop bit 0 or timeout
//   busy        out  1  1 while a frame is in progress (state != IDLE)
// BEHAVIOUR
//   Reset
//     - All outputs are 0.
//     - state=IDLE, filtered ps2_clk=1, shift register and counters are 0.
//     - Reset mid-frame discards the partial frame; no pulse is generated.
//   Input conditioning
//     - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
//     - The filtered clock changes only after FILTER_LEN consecutive clk samples
//       of the new level; shorter glitches are ignored.
//     - fall_evt is a one-cycle pulse on each 1->0 transition of the filtered clock.
//     - At fall_evt, the synchronised ps2_data is the sampled bit.
//   FSM (advances only on fall_evt, except timeout)
//     - IDLE: bit=0 (start) -> DATA, bit_cnt=0. bit=1 -> stay; this is not an error.
//     - DATA: shift the bit in LSB first, bit_cnt++. After the 8th bit -> PARITY.
//     - PARITY: store the parity bit -> STOP.
//     - STOP: go to IDLE and check the frame:
//         - stop=1 and ^{byte,parity}==1: scan_code<=byte, last_code<=byte,
//           code_valid pulses.
//         - stop=1 and parity bad: parity_err pulses.
//         - stop=0: frame_err pulses. frame_err has priority; parity_err stays 0.
//   Latency
//     - The result pulse occurs in the cycle after the cycle in which the stop-bit
//       fall_evt is detected.
//     - scan_code and last_code update on the same edge as the pulse.
//     - scan_code holds its value after the pulse.
//   Timeout
//     - In any non-IDLE state, a counter clears on each fall_evt and increments otherwise.
//     - At TIMEOUT_CYCLES: go to IDLE, frame_err pulses, the partial byte is dropped,
//       last_code is unchanged.
//     - If timeout and a stop-bit fall_evt occur in the same cycle, fall_evt wins.
//   Error effects
//     - Errors never modify last_code or scan_code.
//     - At most one of code_valid, parity_err, frame_err is high in any cycle.
//   Scope
//     - Receive-only: never drives ps2_clk or ps2_data.
//     - Make/break (F0) interpretation is downstream.
// TESTING
//   (PS/2 clock period 40 us @ 50 MHz clk)
//   1. Frame 0x1C, parity=0, stop=1 -> one code_valid pulse, scan_code=last_code=0x1C,
//      busy falls.
//   2. 0xF0 (parity=1), then 0x1C back-to-back -> two pulses; last_code goes 0xF0, then 0x1C.
//   3. 0x1C with parity=1 -> parity_err pulse only; last_code keeps its prior value (0x00
//      after reset).
//   4. 0x32 with stop=0 -> frame_err pulse only; no code_valid, parity_err=0.
//   5. ps2_clk halts after 5 data bits for >50000 cycles -> frame_err, busy=0; a following
//      0x32 frame -> code_valid, last_code=0x32.
//   6. Two faults:
//      - 3-cycle low glitch on ps2_clk in IDLE and mid-frame -> no bit counted, frame
//        still decodes.
//      - rst_n low mid-frame -> all outputs 0, no pulses, next frame decodes correctly.

Source files
------------

// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard frame receiver.
// Conditions the raw device clock and data, decodes 11-bit odd-parity frames
// (start, 8 data bits LSB first, parity, stop) and reports each frame result
// as a one-cycle pulse. The last good code is held for the display decoders.
`timescale 1ns/1ps

module ps2_scancode_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic [7:0] last_code,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state, state_next;

    logic          clk_meta, clk_sync;
    logic          data_meta, data_sync;
    logic          filt_clk, filt_clk_d;
    logic [FW-1:0] filt_cnt;
    logic          fall_evt;

    logic [7:0]    shift_reg, shift_next;
    logic [2:0]    bit_cnt, bit_cnt_next;
    logic          parity_bit, parity_next;
    logic [TW-1:0] timeout_cnt, timeout_next;
    logic [7:0]    scan_next, last_next;
    logic          valid_next, perr_next, ferr_next;

    // Two-flop synchronisers; both lines idle high so they reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // Glitch filter: accept a new clock level only after FILTER_LEN equal samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_sync != filt_clk) begin
                if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                    filt_clk <= clk_sync;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + FW'(1);
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall_evt = filt_clk_d & ~filt_clk;
    assign busy     = (state != IDLE);

    // State register plus all frame datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            parity_bit  <= 1'b0;
            timeout_cnt <= '0;
            scan_code   <= '0;
            last_code   <= '0;
            code_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_next;
            shift_reg   <= shift_next;
            bit_cnt     <= bit_cnt_next;
            parity_bit  <= parity_next;
            timeout_cnt <= timeout_next;
            scan_code   <= scan_next;
            last_code   <= last_next;
            code_valid  <= valid_next;
            parity_err  <= perr_next;
            frame_err   <= ferr_next;
        end
    end

    // Next-state decode: advance on filtered clock falls, abort on a stalled clock.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        parity_next  = parity_bit;
        timeout_next = timeout_cnt;
        scan_next    = scan_code;
        last_next    = last_code;
        valid_next   = 1'b0;
        perr_next    = 1'b0;
        ferr_next    = 1'b0;

        case (state)
            IDLE: begin
                timeout_next = '0;
                if (fall_evt && !data_sync) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    shift_next   = '0;
                end
            end
            DATA: begin
                if (fall_evt) begin
                    shift_next   = {data_sync, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_evt) begin
                    parity_next = data_sync;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (fall_evt) begin
                    state_next = IDLE;
                    if (!data_sync) begin
                        ferr_next = 1'b1;
                    end else if (^{shift_reg, parity_bit}) begin
                        valid_next = 1'b1;
                        scan_next  = shift_reg;
                        last_next  = shift_reg;
                    end else begin
                        perr_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state != IDLE) begin
            if (fall_evt) begin
                timeout_next = '0;
            end else if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state_next   = IDLE;
                ferr_next    = 1'b1;
                timeout_next = '0;
            end else begin
                timeout_next = timeout_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Scoreboard bench for the PS/2 scan-code receiver.
// Frames are driven bit by bit; each frame's expected outcome is queued when it
// is sent, and an independent monitor pops and compares on every result pulse.
`timescale 1ns/1ps

module tb_ps2_scancode_receiver;

    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int HALF           = 30;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid;
    logic [7:0] last_code;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    typedef struct {
        int         kind;
        logic [7:0] scan;
        logic [7:0] last;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         passed = 0;
    int         total  = 0;
    logic [7:0] model_scan = 8'h00;
    logic [7:0] model_last = 8'h00;

    ps2_scancode_receiver #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .scan_code (scan_code),
        .code_valid(code_valid),
        .last_code (last_code),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // 50 MHz system clock.
    always #10 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: kind 0 = good code, 1 = parity error, 2 = framing error.
    task automatic predict(input logic [7:0] b, input logic par, input logic stop);
        exp_t e;
        if (!stop) begin
            e.kind = 2;
        end else if ((($countones(b) + int'(par)) % 2) == 1) begin
            e.kind     = 0;
            model_scan = b;
            model_last = b;
        end else begin
            e.kind = 1;
        end
        e.scan = model_scan;
        e.last = model_last;
        exp_q.push_back(e);
    endtask

    task automatic predictAbort();
        exp_t e;
        e.kind = 2;
        e.scan = model_scan;
        e.last = model_last;
        exp_q.push_back(e);
    endtask

    // One PS/2 bit: data set at the start of the high phase, then a falling edge.
    task automatic sendBit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            waitCycles(10);
            ps2_clk = 1'b0;
            waitCycles(3);
            ps2_clk = 1'b1;
            waitCycles(HALF - 13);
        end else begin
            waitCycles(HALF);
        end
        ps2_clk = 1'b0;
        waitCycles(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                                 input int glitch_bit);
        logic        par;
        logic [10:0] frame;
        par   = (~(^b)) ^ bad_par;
        frame = {~bad_stop, par, b, 1'b0};
        predict(b, par, ~bad_stop);
        for (int i = 0; i < 11; i++) begin
            sendBit(frame[i], glitch_bit == i);
            if (i == 0) checkOutput("busy_in_frame", int'(busy), 1);
        end
        ps2_data = 1'b1;
        checkOutput("busy_after_frame", int'(busy), 0);
    endtask

    task automatic sendPartial(input int n);
        logic [10:0] frame;
        frame = {2'b11, 8'($urandom), 1'b0};
        for (int i = 0; i < n; i++) sendBit(frame[i], 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_scan_code"},  int'(scan_code),  0);
        checkOutput({tag, "_last_code"},  int'(last_code),  0);
        checkOutput({tag, "_code_valid"}, int'(code_valid), 0);
        checkOutput({tag, "_parity_err"}, int'(parity_err), 0);
        checkOutput({tag, "_frame_err"},  int'(frame_err),  0);
        checkOutput({tag, "_busy"},       int'(busy),       0);
    endtask

    // Monitor: every result pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (code_valid || parity_err || frame_err) begin
            checkOutput("single_pulse", int'(code_valid) + int'(parity_err) + int'(frame_err), 1);
            if (exp_q.size() == 0) begin
                total++;
                $display("[TB] FAIL unexpected_pulse: got valid=%0d perr=%0d ferr=%0d, expected none",
                         code_valid, parity_err, frame_err);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("pulse_kind", code_valid ? 0 : (parity_err ? 1 : 2), mon_e.kind);
                checkOutput("scan_code", int'(scan_code), int'(mon_e.scan));
                checkOutput("last_code", int'(last_code), int'(mon_e.last));
            end
        end
    end

    // Watchdog so the bench always reaches an end.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized frames.
    initial begin
        logic [7:0] rb;
        int         r;

        waitCycles(5);
        checkAllZero("reset");
        rst_n = 1'b1;
        waitCycles(20);

        applyStimulus(8'h1C, 1'b0, 1'b0, -1);
        waitCycles(10);

        applyStimulus(8'hF0, 1'b0, 1'b0, -1);
        applyStimulus(8'h1C, 1'b0, 1'b0, -1);
        waitCycles(10);

        applyStimulus(8'h1C, 1'b1, 1'b0, -1);
        waitCycles(10);

        applyStimulus(8'h32, 1'b0, 1'b1, -1);
        waitCycles(10);

        predictAbort();
        sendPartial(6);
        waitCycles(TIMEOUT_CYCLES + 300);
        checkOutput("busy_after_timeout", int'(busy), 0);
        checkOutput("timeout_reported", exp_q.size(), 0);
        applyStimulus(8'h32, 1'b0, 1'b0, -1);
        waitCycles(20);

        ps2_clk = 1'b0;
        waitCycles(3);
        ps2_clk = 1'b1;
        waitCycles(20);
        checkOutput("busy_after_idle_glitch", int'(busy), 0);
        applyStimulus(8'hA5, 1'b0, 1'b0, 4);
        waitCycles(10);

        sendPartial(5);
        rst_n = 1'b0;
        waitCycles(3);
        checkAllZero("mid_reset");
        model_scan = 8'h00;
        model_last = 8'h00;
        rst_n = 1'b1;
        waitCycles(20);
        applyStimulus(8'h1C, 1'b0, 1'b0, -1);
        waitCycles(10);

        for (int n = 0; n < 16; n++) begin
            rb = 8'($urandom);
            r  = int'($urandom_range(0, 9));
            applyStimulus(rb, r < 2, r == 9, -1);
            waitCycles(int'($urandom_range(0, 40)));
        end

        waitCycles(100);
        checkOutput("all_expected_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
